lcd_nibble_sequencer: RTL and testbench
=======================================

LCD_NIBBLE_SEQUENCER -- requirements
Module: lcd_nibble_sequencer

Interface
REQ-001 The block SHALL have one clock, Clock, and its reset, Reset, SHALL be synchronous and active-high.
REQ-002 Parameters (all values in Clock cycles) SHALL be:
- T_POR, 750000, power-on wait.
- T_INIT1, 205000, wait after init nibble 0.
- T_INIT2, 5000, wait after init nibble 1.
- T_INIT3, 2000, wait after init nibbles 2 and 3.
- T_SETUP, 2, data/RS setup before E rises.
- T_EN, 12, E high width.
- T_HOLD, 1, data hold after E falls.
- T_GAP, 50, wait after a high nibble.
- T_CMD, 2000, wait after a low nibble.
- T_CLEAR, 82000, wait after a low nibble completing byte 0x01 or 0x02 with RS=0.
REQ-003 Ports SHALL be:
- Clock  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- iLCD_data  in  4  nibble to send.
- iLCD_rs  in  1  register select for that nibble (0 command, 1 data).
- iLCD_writeEN  in  1  write request; sampled only when not busy.
- oLCD_response  out  1  busy (1) / ready (0).
- oLCD_Data  out  4  LCD DB[7:4].
- oLCD_Enabled  out  1  LCD E.
- oLCD_RegisterSelect  out  1  LCD RS.
- oLCD_ReadWrite  out  1  LCD R/W, constant 0.
- oLCD_StrataFlashControl  out  1  constant 1.

Function
REQ-004 States SHALL be POR_WAIT, INIT_SETUP, INIT_EN, INIT_HOLD, INIT_WAIT, IDLE, SETUP, ENABLE, HOLD, WAIT.
REQ-005 POR_WAIT SHALL hold for T_POR cycles, then go to INIT_SETUP with init step = 0.
REQ-006 Init sequence:
- Steps 0..3 SHALL send nibbles 0x3, 0x3, 0x3, 0x2, each with RS=0.
- Each step SHALL use T_SETUP/T_EN/T_HOLD timing.
- INIT_WAIT duration SHALL be T_INIT1, T_INIT2, T_INIT3, T_INIT3 for steps 0..3 respectively.
- After step 3 the block SHALL enter IDLE with the nibble phase set to HIGH.
REQ-007 oLCD_response SHALL be 0 only in IDLE and 1 in every other state.
REQ-008 In IDLE, iLCD_writeEN=1 SHALL:
- latch iLCD_data and iLCD_rs;
- drive oLCD_Data and oLCD_RegisterSelect from the latched values;
- enter SETUP on the next edge, with oLCD_response=1 from that edge onward.
REQ-009 iLCD_writeEN asserted outside IDLE SHALL be ignored; no queueing.
REQ-010 Write pulse timing:
- SETUP SHALL last T_SETUP cycles with E=0.
- ENABLE SHALL last T_EN cycles with E=1.
- HOLD SHALL last T_HOLD cycles with E=0.
- oLCD_Data and oLCD_RegisterSelect SHALL stay stable from SETUP through HOLD.
REQ-011 WAIT duration after HOLD:
- T_GAP if the phase was HIGH; the high nibble and RS SHALL be stored.
- T_CMD if the phase was LOW.
- T_CLEAR instead of T_CMD if the phase was LOW, the stored RS=0, the current RS=0, and {stored high nibble, low nibble} equals 0x01 or 0x02.
REQ-012 The phase SHALL toggle at the end of each WAIT, and WAIT SHALL return to IDLE.
REQ-013 One cycle-down counter of at least 20 bits SHALL time all states. Each state SHALL last exactly its parameter value in cycles; a parameter value of 0 SHALL be treated as 1.
REQ-014 Total latency from an accepted write to oLCD_response=0 SHALL be 1 + T_SETUP + T_EN + T_HOLD + (applicable wait) cycles.
REQ-015 oLCD_ReadWrite SHALL always be 0, and oLCD_StrataFlashControl SHALL always be 1.

Reset
REQ-016 Reset=1 at any clock edge, in any state (including mid-pulse with E=1), SHALL on that edge:
- enter POR_WAIT;
- set oLCD_Enabled=0, oLCD_Data=0, oLCD_RegisterSelect=0, oLCD_response=1;
- set the phase to HIGH, clear the stored nibble, set init step = 0.
REQ-017 While Reset stays high, the outputs SHALL hold these values and the counters SHALL not advance.

Verification
REQ-018 The bench SHALL use parameters T_POR=20, T_INIT1=8, T_INIT2=4, T_INIT3=3, T_SETUP=2, T_EN=3, T_HOLD=1, T_GAP=3, T_CMD=6, T_CLEAR=30.
REQ-019 Power-up: release Reset -> four E pulses with Data 3,3,3,2 at RS=0; first E rises 22 cycles after release; each pulse is 3 cycles wide; oLCD_response falls after the last INIT_WAIT.
REQ-020 Data byte: in IDLE, write nibble 0x4 then 0x1 with rs=1 -> RS=1 on both pulses; busy for 1+2+3+1+3=10 cycles after the first write and 1+2+3+1+6=13 cycles after the second.
REQ-021 Clear: write 0x0 then 0x1 with rs=0 -> wait after the second nibble is 30 cycles (total busy 37 cycles); the same sequence with rs=1 waits 6 cycles.
REQ-022 Dropped request: hold iLCD_writeEN=1 with data 0xA during busy -> exactly one E pulse per IDLE acceptance; the value presented while busy never appears on oLCD_Data.
REQ-023 Reset mid-pulse: assert Reset while E=1 -> E=0 and oLCD_response=1 on the same edge; after release, the full init sequence repeats and the phase restarts at HIGH.

Source files
------------

// File: rtl/lcd_nibble_sequencer.sv
// 4-bit HD44780-style LCD write sequencer: power-on init (3,3,3,2) then
// one E strobe per accepted nibble, with a per-nibble settle wait afterwards.
//
// state      | meaning
// POR_WAIT   | power-on delay before any LCD access
// INIT_SETUP | init nibble on DB/RS, E low
// INIT_EN    | init nibble, E high
// INIT_HOLD  | init nibble, E low, data held
// INIT_WAIT  | per-step init settle time
// IDLE       | ready, accepts one write request
// SETUP      | user nibble on DB/RS, E low
// ENABLE     | user nibble, E high
// HOLD       | user nibble, E low, data held
// WAIT       | gap / command / clear settle time, then phase toggles
module lcd_nibble_sequencer #(
    parameter int unsigned T_POR   = 750000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000,
    parameter int unsigned T_INIT3 = 2000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_GAP   = 50,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLEAR = 82000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] iLCD_data,
    input  logic       iLCD_rs,
    input  logic       iLCD_writeEN,
    output logic       oLCD_response,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl
);

    typedef enum logic [3:0] {
        POR_WAIT,
        INIT_SETUP,
        INIT_EN,
        INIT_HOLD,
        INIT_WAIT,
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        WAIT
    } state_t;

    // A state lasting T cycles loads T-1; zero-length states still take one cycle.
    function automatic logic [CNT_W-1:0] ld(input int unsigned t);
        if (t == 0) return '0;
        return CNT_W'(t - 1);
    endfunction

    function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] step);
        case (step)
            2'd0:    return ld(T_INIT1);
            2'd1:    return ld(T_INIT2);
            default: return ld(T_INIT3);
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       step_q, step_d;
    logic             phase_low_q, phase_low_d;
    logic [3:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic             hi_rs_q, hi_rs_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;

    logic cnt_done;
    logic is_clear;

    assign cnt_done = (cnt_q == '0);
    assign is_clear = !hi_rs_q && !rs_q &&
                      (({hi_nib_q, data_q} == 8'h01) || ({hi_nib_q, data_q} == 8'h02));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_done ? cnt_q : cnt_q - 1'b1;
        step_d      = step_q;
        phase_low_d = phase_low_q;
        data_d      = data_q;
        rs_d        = rs_q;
        hi_nib_d    = hi_nib_q;
        hi_rs_d     = hi_rs_q;

        case (state_q)
            POR_WAIT: begin
                if (cnt_done) begin
                    state_d = INIT_SETUP;
                    cnt_d   = ld(T_SETUP);
                    step_d  = 2'd0;
                    data_d  = 4'h3;
                    rs_d    = 1'b0;
                end
            end
            INIT_SETUP: begin
                if (cnt_done) begin
                    state_d = INIT_EN;
                    cnt_d   = ld(T_EN);
                end
            end
            INIT_EN: begin
                if (cnt_done) begin
                    state_d = INIT_HOLD;
                    cnt_d   = ld(T_HOLD);
                end
            end
            INIT_HOLD: begin
                if (cnt_done) begin
                    state_d = INIT_WAIT;
                    cnt_d   = init_wait(step_q);
                end
            end
            INIT_WAIT: begin
                if (cnt_done) begin
                    if (step_q == 2'd3) begin
                        state_d     = IDLE;
                        phase_low_d = 1'b0;
                    end else begin
                        state_d = INIT_SETUP;
                        cnt_d   = ld(T_SETUP);
                        step_d  = step_q + 2'd1;
                        data_d  = (step_q == 2'd2) ? 4'h2 : 4'h3;
                        rs_d    = 1'b0;
                    end
                end
            end
            IDLE: begin
                if (iLCD_writeEN) begin
                    state_d = SETUP;
                    cnt_d   = ld(T_SETUP);
                    data_d  = iLCD_data;
                    rs_d    = iLCD_rs;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    state_d = ENABLE;
                    cnt_d   = ld(T_EN);
                end
            end
            ENABLE: begin
                if (cnt_done) begin
                    state_d = HOLD;
                    cnt_d   = ld(T_HOLD);
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    state_d = WAIT;
                    if (!phase_low_q) begin
                        cnt_d    = ld(T_GAP);
                        hi_nib_d = data_q;
                        hi_rs_d  = rs_q;
                    end else if (is_clear) begin
                        cnt_d = ld(T_CLEAR);
                    end else begin
                        cnt_d = ld(T_CMD);
                    end
                end
            end
            WAIT: begin
                if (cnt_done) begin
                    state_d     = IDLE;
                    phase_low_d = !phase_low_q;
                end
            end
            default: begin
                state_d = POR_WAIT;
                cnt_d   = ld(T_POR);
            end
        endcase

        // E and busy are registered so the LCD strobe never sees decode glitches.
        e_d    = (state_d == INIT_EN) || (state_d == ENABLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= POR_WAIT;
            cnt_q       <= ld(T_POR);
            step_q      <= 2'd0;
            phase_low_q <= 1'b0;
            data_q      <= 4'h0;
            rs_q        <= 1'b0;
            hi_nib_q    <= 4'h0;
            hi_rs_q     <= 1'b0;
            e_q         <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            phase_low_q <= phase_low_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            hi_nib_q    <= hi_nib_d;
            hi_rs_q     <= hi_rs_d;
            e_q         <= e_d;
            busy_q      <= busy_d;
        end
    end

    assign oLCD_response           = busy_q;
    assign oLCD_Data               = data_q;
    assign oLCD_Enabled            = e_q;
    assign oLCD_RegisterSelect     = rs_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Directed bench for lcd_nibble_sequencer using shortened timing parameters;
// edges are counted from the stimulus side and outputs sampled 1ns after posedge.
module tb_lcd_nibble_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] wr_data = 4'h0;
    logic       wr_rs = 1'b0;
    logic       wr_en = 1'b0;

    logic       oLCD_response;
    logic [3:0] oLCD_Data;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic       oLCD_StrataFlashControl;

    int checks = 0;
    int errors = 0;

    // init-sequence observations, filled by watch_init
    int         rise_t [4];
    logic [3:0] rise_d [4];
    logic       rise_rs [4];
    int         width_t [4];
    int         n_pulse;
    int         idle_t;

    always #5 Clock = ~Clock;

    lcd_nibble_sequencer #(
        .T_POR(20), .T_INIT1(8), .T_INIT2(4), .T_INIT3(3),
        .T_SETUP(2), .T_EN(3), .T_HOLD(1),
        .T_GAP(3), .T_CMD(6), .T_CLEAR(30)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iLCD_data               (wr_data),
        .iLCD_rs                 (wr_rs),
        .iLCD_writeEN            (wr_en),
        .oLCD_response           (oLCD_response),
        .oLCD_Data               (oLCD_Data),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl)
    );

    // Issues one write from IDLE and follows it until ready again.
    // busy counts edges from the accepting edge to the edge where ready returns.
    task automatic do_write(input logic [3:0] d, input logic r, output int busy,
                            output int pulses, output logic [3:0] d_e,
                            output logic rs_e, output logic stable);
        logic prev_e;
        @(negedge Clock);
        wr_data = d;
        wr_rs   = r;
        wr_en   = 1'b1;
        @(posedge Clock);
        #1;
        wr_en   = 1'b0;
        wr_data = ~d;
        wr_rs   = ~r;
        busy    = 1;
        pulses  = 0;
        d_e     = 4'h0;
        rs_e    = 1'b0;
        prev_e  = 1'b0;
        stable  = (oLCD_Data === d) && (oLCD_RegisterSelect === r);
        while (oLCD_response !== 1'b0 && busy < 300) begin
            @(posedge Clock);
            #1;
            busy++;
            if (oLCD_Enabled === 1'b1 && !prev_e) begin
                pulses++;
                d_e  = oLCD_Data;
                rs_e = oLCD_RegisterSelect;
            end
            if (oLCD_Data !== d || oLCD_RegisterSelect !== r) stable = 1'b0;
            prev_e = oLCD_Enabled;
        end
    endtask

    // Releases reset and records the init E pulses; edge 1 is the first edge with Reset low.
    task automatic watch_init();
        int   n;
        int   start;
        logic prev_e;
        for (int i = 0; i < 4; i++) begin
            rise_t[i]  = -1;
            rise_d[i]  = 4'h0;
            rise_rs[i] = 1'b1;
            width_t[i] = -1;
        end
        n_pulse = 0;
        idle_t  = -1;
        n       = 0;
        start   = 0;
        prev_e  = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        while (idle_t < 0 && n < 200) begin
            @(posedge Clock);
            #1;
            n++;
            if (oLCD_Enabled === 1'b1 && !prev_e) begin
                if (n_pulse < 4) begin
                    rise_t[n_pulse]  = n;
                    rise_d[n_pulse]  = oLCD_Data;
                    rise_rs[n_pulse] = oLCD_RegisterSelect;
                end
                start = n;
                n_pulse++;
            end
            if (oLCD_Enabled !== 1'b1 && prev_e && n_pulse > 0 && n_pulse <= 4)
                width_t[n_pulse-1] = n - start;
            prev_e = (oLCD_Enabled === 1'b1);
            if (oLCD_response === 1'b0) idle_t = n;
        end
    endtask

    task automatic test_reset();
        logic hold_ok;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (oLCD_response !== 1'b1 || oLCD_Enabled !== 1'b0 ||
            oLCD_Data !== 4'h0 || oLCD_RegisterSelect !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs resp=%b e=%b data=%h rs=%b expected 1 0 0 0",
                     oLCD_response, oLCD_Enabled, oLCD_Data, oLCD_RegisterSelect);
        end
        checks++;
        if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) begin
            errors++;
            $display("FAIL constants rw=%b sf=%b expected 0 1",
                     oLCD_ReadWrite, oLCD_StrataFlashControl);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clock);
            #1;
            if (oLCD_response !== 1'b1 || oLCD_Enabled !== 1'b0 || oLCD_Data !== 4'h0)
                hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL reset_hold outputs moved while Reset high, got resp=%b e=%b expected 1 0",
                     oLCD_response, oLCD_Enabled);
        end
    endtask

    task automatic check_init(input string tag);
        int         exp_rise [4] = '{22, 36, 46, 55};
        logic [3:0] exp_d [4]    = '{4'h3, 4'h3, 4'h3, 4'h2};
        checks++;
        if (n_pulse != 4) begin
            errors++;
            $display("FAIL %s pulse_count got %0d expected 4", tag, n_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rise_t[i] != exp_rise[i] || rise_d[i] !== exp_d[i] ||
                rise_rs[i] !== 1'b0 || width_t[i] != 3) begin
                errors++;
                $display("FAIL %s pulse%0d rise=%0d data=%h rs=%b width=%0d expected %0d %h 0 3",
                         tag, i, rise_t[i], rise_d[i], rise_rs[i], width_t[i],
                         exp_rise[i], exp_d[i]);
            end
        end
        checks++;
        if (idle_t != 62) begin
            errors++;
            $display("FAIL %s ready_edge got %0d expected 62", tag, idle_t);
        end
    endtask

    task automatic test_power_up();
        watch_init();
        check_init("power_up");
    endtask

    task automatic test_data_byte();
        int busy, pulses;
        logic [3:0] d_e;
        logic rs_e, stable;
        do_write(4'h4, 1'b1, busy, pulses, d_e, rs_e, stable);
        checks++;
        if (busy != 10 || pulses != 1 || d_e !== 4'h4 || rs_e !== 1'b1 || !stable) begin
            errors++;
            $display("FAIL data_hi busy=%0d pulses=%0d data=%h rs=%b stable=%b expected 10 1 4 1 1",
                     busy, pulses, d_e, rs_e, stable);
        end
        do_write(4'h1, 1'b1, busy, pulses, d_e, rs_e, stable);
        checks++;
        if (busy != 13 || pulses != 1 || d_e !== 4'h1 || rs_e !== 1'b1 || !stable) begin
            errors++;
            $display("FAIL data_lo busy=%0d pulses=%0d data=%h rs=%b stable=%b expected 13 1 1 1 1",
                     busy, pulses, d_e, rs_e, stable);
        end
    endtask

    task automatic test_clear();
        logic [3:0] hi_d [6] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic [3:0] lo_d [6] = '{4'h1, 4'h1, 4'h2, 4'h3, 4'h1, 4'h1};
        logic       hi_r [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       lo_r [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int         exp_lo [6] = '{37, 13, 37, 13, 13, 13};
        int busy, pulses;
        logic [3:0] d_e;
        logic rs_e, stable;
        for (int i = 0; i < 6; i++) begin
            do_write(hi_d[i], hi_r[i], busy, pulses, d_e, rs_e, stable);
            checks++;
            if (busy != 10) begin
                errors++;
                $display("FAIL clear%0d_hi busy got %0d expected 10", i, busy);
            end
            do_write(lo_d[i], lo_r[i], busy, pulses, d_e, rs_e, stable);
            checks++;
            if (busy != exp_lo[i] || d_e !== lo_d[i] || rs_e !== lo_r[i]) begin
                errors++;
                $display("FAIL clear%0d_lo busy=%0d data=%h rs=%b expected %0d %h %b",
                         i, busy, d_e, rs_e, exp_lo[i], lo_d[i], lo_r[i]);
            end
        end
    endtask

    task automatic test_dropped();
        int   busy, pulses;
        logic prev_e, saw_a, idle_ok;
        logic [3:0] d_e;
        logic rs_e, stable;
        @(negedge Clock);
        wr_data = 4'h5;
        wr_rs   = 1'b1;
        wr_en   = 1'b1;
        @(posedge Clock);
        #1;
        wr_data = 4'hA;
        busy    = 1;
        pulses  = 0;
        prev_e  = 1'b0;
        saw_a   = 1'b0;
        while (oLCD_response !== 1'b0 && busy < 300) begin
            @(posedge Clock);
            #1;
            busy++;
            if (oLCD_Enabled === 1'b1 && !prev_e) pulses++;
            if (oLCD_Data === 4'hA) saw_a = 1'b1;
            prev_e = (oLCD_Enabled === 1'b1);
        end
        wr_en = 1'b0;
        checks++;
        if (busy != 10 || pulses != 1 || saw_a) begin
            errors++;
            $display("FAIL dropped busy=%0d pulses=%0d saw_A=%b expected 10 1 0",
                     busy, pulses, saw_a);
        end
        idle_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock);
            #1;
            if (oLCD_response !== 1'b0 || oLCD_Enabled !== 1'b0 || oLCD_Data === 4'hA)
                idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("FAIL no_queue request replayed after busy, resp=%b data=%h expected 0 5",
                     oLCD_response, oLCD_Data);
        end
        do_write(4'h6, 1'b1, busy, pulses, d_e, rs_e, stable);
        checks++;
        if (busy != 13 || d_e !== 4'h6) begin
            errors++;
            $display("FAIL after_drop_lo busy=%0d data=%h expected 13 6", busy, d_e);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int   busy, pulses, n;
        logic [3:0] d_e;
        logic rs_e, stable, hold_ok;
        do_write(4'h7, 1'b1, busy, pulses, d_e, rs_e, stable);
        checks++;
        if (busy != 10) begin
            errors++;
            $display("FAIL mid_pre_hi busy got %0d expected 10", busy);
        end
        @(negedge Clock);
        wr_data = 4'h8;
        wr_rs   = 1'b1;
        wr_en   = 1'b1;
        @(posedge Clock);
        #1;
        wr_en = 1'b0;
        n = 0;
        while (oLCD_Enabled !== 1'b1 && n < 50) begin
            @(posedge Clock);
            #1;
            n++;
        end
        @(negedge Clock);
        checks++;
        if (oLCD_Enabled !== 1'b1) begin
            errors++;
            $display("FAIL mid_e_high e=%b expected 1", oLCD_Enabled);
        end
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (oLCD_Enabled !== 1'b0 || oLCD_response !== 1'b1 ||
            oLCD_Data !== 4'h0 || oLCD_RegisterSelect !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset e=%b resp=%b data=%h rs=%b expected 0 1 0 0",
                     oLCD_Enabled, oLCD_response, oLCD_Data, oLCD_RegisterSelect);
        end
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1;
            if (oLCD_Enabled !== 1'b0 || oLCD_response !== 1'b1 || oLCD_Data !== 4'h0)
                hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL mid_reset_hold outputs moved while Reset high, got e=%b resp=%b",
                     oLCD_Enabled, oLCD_response);
        end
        watch_init();
        check_init("reinit");
        do_write(4'h0, 1'b0, busy, pulses, d_e, rs_e, stable);
        checks++;
        if (busy != 10) begin
            errors++;
            $display("FAIL reinit_phase_hi busy got %0d expected 10", busy);
        end
        do_write(4'h1, 1'b0, busy, pulses, d_e, rs_e, stable);
        checks++;
        if (busy != 37) begin
            errors++;
            $display("FAIL reinit_phase_lo busy got %0d expected 37", busy);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_data_byte();
        test_clear();
        test_dropped();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
